lsu_store_buffer_bridge: RTL

//  Parametrised MEM-stage load/store bridge between the pipeline and the data bus.

---
 rtl/lsu_pkg.sv | 47 ++++
 rtl/lsu_lane_align.sv | 68 ++++++
 rtl/lsu_store_buffer_bridge.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared access-mode codes, load FSM encoding and lane helpers
// for the MEM-stage store-buffer bridge.
package lsu_pkg;

  localparam logic [3:0] M_WORD  = 4'd0;
  localparam logic [3:0] M_BYTE  = 4'd1;
  localparam logic [3:0] M_HALF  = 4'd2;
  localparam logic [3:0] M_BYTEU = 4'd3;
  localparam logic [3:0] M_HALFU = 4'd4;
  localparam logic [3:0] M_DWORD = 4'd5;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    L_IDLE = 2'd0,
    L_REQ  = 2'd1,
    L_WAIT = 2'd2
  } lstate_t;

  function automatic int lanes(input int dw);
    return dw / 8;
  endfunction

  // access size; DWORD folds to WORD on a 32-bit bus
  function automatic logic [1:0] mode_size(
    input logic [3:0] m,
    input logic       wide
  );
    logic [1:0] s;
    s = SZ_W;
    unique case (1'b1)
      (m == M_BYTE) || (m == M_BYTEU): s = SZ_B;
      (m == M_HALF) || (m == M_HALFU): s = SZ_H;
      (m == M_DWORD):                  s = wide ? SZ_D : SZ_W;
      default:                         s = SZ_W;
    endcase
    return s;
  endfunction

  function automatic logic mode_unsigned(input logic [3:0] m);
    return (m == M_BYTEU) || (m == M_HALFU);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: store byte-enable / lane replication (LOAD=0)
// or load lane extraction with sign/zero extension (LOAD=1).
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter bit LOAD   = 1'b0
) (
  input  logic [3:0]                  mode,
  input  logic [$clog2(DATA_W/8)-1:0] off,
  input  logic [DATA_W-1:0]           din,
  output logic [DATA_W/8-1:0]         be,
  output logic [DATA_W-1:0]           dout
);

  localparam int  NL   = lanes(DATA_W);
  localparam logic WIDE = (DATA_W == 64);

  logic [1:0] sz;
  assign sz = mode_size(mode, WIDE);

  if (LOAD) begin : g_ld
    logic [DATA_W-1:0] sh;
    logic              sx8;
    logic              sx16;

    assign sh   = din >> {off, 3'b000};
    assign sx8  = ~mode_unsigned(mode) & sh[7];
    assign sx16 = ~mode_unsigned(mode) & sh[15];
    assign be   = '1;

    // pick the addressed lane and extend it to full width
    always_comb begin
      dout = sh;
      unique case (sz)
        SZ_B:    dout = {{(DATA_W-8){sx8}}, sh[7:0]};
        SZ_H:    dout = {{(DATA_W-16){sx16}}, sh[15:0]};
        SZ_W:    dout = DATA_W'($signed(sh[31:0]));
        default: dout = sh;
      endcase
    end
  end else begin : g_st
    // replicate store data into every lane and enable the addressed bytes
    always_comb begin
      be   = '0;
      dout = din;
      unique case (sz)
        SZ_B: begin
          be   = NL'(1) << off;
          dout = {NL{din[7:0]}};
        end
        SZ_H: begin
          be   = NL'(3) << off;
          dout = {(NL/2){din[15:0]}};
        end
        SZ_W: begin
          be   = NL'(15) << off;
          dout = {(NL/4){din[31:0]}};
        end
        default: begin
          be   = '1;
          dout = din;
        end
      endcase
    end
  end

endmodule

// File: rtl/lsu_store_buffer_bridge.sv
// lsu_store_buffer_bridge: MEM-stage store FIFO + blocking load FSM.
// Optional LSU_ALIGN_EXC_EN raises AdEL/AdES on misaligned accesses.
module lsu_store_buffer_bridge
  import lsu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int SBUF_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [3:0]          req_mode,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic                int_req,
  output logic                ld_valid,
  output logic [DATA_W-1:0]   ld_data,
  output logic                exc_valid,
  output logic                exc_store,
  output logic                busy,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W/8-1:0] m_byteen,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam int   NL   = lanes(DATA_W);
  localparam int   LB   = $clog2(NL);
  localparam int   PW   = $clog2(SBUF_DEPTH);
  localparam logic WIDE = (DATA_W == 64);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(SBUF_DEPTH);

  lstate_t fsm;

  logic [ADDR_W-1:0] q_addr [SBUF_DEPTH];
  logic [NL-1:0]     q_be   [SBUF_DEPTH];
  logic [DATA_W-1:0] q_data [SBUF_DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW:0]       count;

  logic [ADDR_W-1:0] ld_addr;
  logic [3:0]        ld_mode;
  logic [LB-1:0]     ld_off;

  logic              idle;
  logic              full;
  logic              empty;
  logic              acc;
  logic              misal;
  logic              push;
  logic              pop;
  logic              ld_go;
  logic              drain;
  logic [1:0]        sz;
  logic [LB-1:0]     off;
  logic [LB-1:0]     amask;
  logic [LB-1:0]     off_al;
  logic [ADDR_W-1:0] addr_al;
  logic [NL-1:0]     st_be;
  logic [DATA_W-1:0] st_wdata;
  logic [NL-1:0]     ld_be;
  logic [DATA_W-1:0] ld_ext;

  assign idle  = (fsm == L_IDLE);
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  assign req_ready = idle && !full &&
                     (req_we || !req_valid || empty);
  assign acc = req_valid && req_ready;

  assign sz      = mode_size(req_mode, WIDE);
  assign off     = req_addr[LB-1:0];
  assign amask   = LB'((4'd1 << sz) - 4'd1);
  assign off_al  = off & ~amask;
  assign addr_al = {req_addr[ADDR_W-1:LB], {LB{1'b0}}};

`ifdef LSU_ALIGN_EXC_EN
  assign misal = |(off & amask);
`else
  assign misal = 1'b0;
`endif

  assign push  = acc && req_we && !int_req && !misal;
  assign ld_go = acc && !req_we && !misal;
  assign drain = idle && !empty;
  assign pop   = drain && m_ready;

  lsu_lane_align #(
    .DATA_W (DATA_W),
    .LOAD   (1'b0)
  ) u_st_align (
    .mode (req_mode),
    .off  (off_al),
    .din  (req_wdata),
    .be   (st_be),
    .dout (st_wdata)
  );

  lsu_lane_align #(
    .DATA_W (DATA_W),
    .LOAD   (1'b1)
  ) u_ld_align (
    .mode (ld_mode),
    .off  (ld_off),
    .din  (m_rdata),
    .be   (ld_be),
    .dout (ld_ext)
  );

  assign m_valid  = drain || (fsm == L_REQ);
  assign m_we     = drain;
  assign m_addr   = drain ? q_addr[head] :
                    (fsm == L_REQ) ? ld_addr : '0;
  assign m_byteen = drain ? q_be[head] :
                    (fsm == L_REQ) ? ld_be : '0;
  assign m_wdata  = drain ? q_data[head] : '0;
  assign busy     = !empty || !idle;

  // store entry capture at the tail
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail] <= addr_al;
      q_be[tail]   <= st_be;
      q_data[tail] <= st_wdata;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // blocking load sequencer with registered result
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm      <= L_IDLE;
      ld_valid <= 1'b0;
      ld_data  <= '0;
      ld_addr  <= '0;
      ld_mode  <= '0;
      ld_off   <= '0;
    end else begin
      ld_valid <= 1'b0;
      unique case (fsm)
        L_IDLE: begin
          if (ld_go) begin
            fsm     <= L_REQ;
            ld_addr <= addr_al;
            ld_mode <= req_mode;
            ld_off  <= off_al;
          end
        end
        L_REQ: begin
          if (m_ready) fsm <= L_WAIT;
        end
        L_WAIT: begin
          if (m_rvalid) begin
            fsm      <= L_IDLE;
            ld_valid <= 1'b1;
            ld_data  <= ld_ext;
          end
        end
        default: fsm <= L_IDLE;
      endcase
    end
  end

`ifdef LSU_ALIGN_EXC_EN
  // misalignment exception pulse, one cycle after accept
  always_ff @(posedge clk) begin
    if (reset) begin
      exc_valid <= 1'b0;
      exc_store <= 1'b0;
    end else begin
      exc_valid <= acc && misal && !(req_we && int_req);
      exc_store <= acc && misal && req_we && !int_req;
    end
  end
`else
  assign exc_valid = 1'b0;
  assign exc_store = 1'b0;
`endif

endmodule
